display_mode_ctrl: RTL and testbench

//  Frame-synchronous scheduler that chooses which image source drives the 1280x720 display.
//  It takes debounced key pulses (next/prev/auto) and queues each requested source change.
//  The change is applied only on a frame_start boundary, and the output is blanked for

---
 rtl/display_mode_ctrl.sv | 137 +++++++++++++
 tb/tb_display_mode_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_ctrl.sv
// Frame-synchronous source scheduler for the 1280x720 display: queues key requests,
// switches mode_sel only on frame_start and blanks for BLANK_FRAMES frames afterwards.
module display_mode_ctrl #(
  parameter int NUM_MODES    = 4,
  parameter int MODE_W       = 2,
  parameter int AUTO_FRAMES  = 120,
  parameter int BLANK_FRAMES = 1
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              key_next,
  input  logic              key_prev,
  input  logic              key_auto,
  output logic [MODE_W-1:0] mode_sel,
  output logic              blank,
  output logic              pending,
  output logic              auto_en,
  output logic              switch_done
);

  localparam int AUTO_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

  localparam logic [1:0] S_SHOW  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam logic [AUTO_W-1:0] AUTO_LAST  = AUTO_W'(AUTO_FRAMES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [3:0]        BLANK_INIT = 4'(BLANK_FRAMES);

  logic [1:0]        state;
  logic [MODE_W-1:0] target;
  logic [MODE_W-1:0] base;
  logic [MODE_W-1:0] req_target;
  logic [AUTO_W-1:0] auto_cnt;
  logic [3:0]        blank_cnt;
  logic              manual_key;
  logic              manual_req;
  logic              auto_step;
  logic              req;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    manual_key = key_next | key_prev;
    manual_req = key_next ^ key_prev;
    // A manual key or a slideshow toggle in the same cycle suppresses the slideshow step.
    auto_step  = auto_en && !key_auto && !manual_key && (state == S_SHOW) &&
                 frame_start && (auto_cnt == AUTO_LAST);
    req        = manual_req | auto_step;
    base       = pending ? target : mode_sel;
    if (key_prev && !key_next) begin
      req_target = (base == '0) ? MODE_LAST : base - 1'b1;
    end else begin
      req_target = (base == MODE_LAST) ? '0 : base + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; a later assignment in this
  // block overrides an earlier default for the same edge.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_SHOW;
      target      <= '0;
      mode_sel    <= '0;
      blank       <= 1'b0;
      pending     <= 1'b0;
      auto_en     <= 1'b0;
      switch_done <= 1'b0;
      auto_cnt    <= '0;
      blank_cnt   <= '0;
    end else begin
      switch_done <= 1'b0;

      if (key_auto) begin
        auto_en <= !auto_en;
      end

      if ((key_auto && auto_en) || manual_key || auto_step) begin
        auto_cnt <= '0;
      end else if (auto_en && (state == S_SHOW) && frame_start) begin
        auto_cnt <= auto_cnt + 1'b1;
      end

      if (req) begin
        target  <= req_target;
        pending <= 1'b1;
      end

      case (state)
        S_SHOW: begin
          if (req) begin
            state <= S_PEND;
          end
        end

        // A request landing on the same frame_start keeps the change queued one more frame.
        S_PEND: begin
          if (frame_start && !req) begin
            pending <= 1'b0;
            if (target == mode_sel) begin
              state <= S_SHOW;
            end else begin
              mode_sel <= target;
              if (BLANK_FRAMES > 0) begin
                blank     <= 1'b1;
                blank_cnt <= BLANK_INIT;
                state     <= S_BLANK;
              end else begin
                switch_done <= 1'b1;
                auto_cnt    <= '0;
                state       <= S_SHOW;
              end
            end
          end
        end

        S_BLANK: begin
          if (frame_start) begin
            if (blank_cnt <= 4'd1) begin
              blank       <= 1'b0;
              blank_cnt   <= 4'd0;
              switch_done <= 1'b1;
              auto_cnt    <= '0;
              state       <= (pending || req) ? S_PEND : S_SHOW;
            end else begin
              blank_cnt <= blank_cnt - 4'd1;
            end
          end
        end

        default: state <= S_SHOW;
      endcase
    end
  end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Scoreboard bench for display_mode_ctrl: every expected output change is queued with
// its clock edge; a negedge monitor pops and compares whenever the outputs change.
module tb_display_mode_ctrl;

  logic       vga_clk = 1'b0;
  logic       sys_rst;
  logic       frame_start = 1'b0;
  logic       key_next = 1'b0;
  logic       key_prev = 1'b0;
  logic       key_auto = 1'b0;
  logic [1:0] mode_sel;
  logic       blank;
  logic       pending;
  logic       auto_en;
  logic       switch_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_evt   = 0;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  exp_t       q[$];
  logic [5:0] prev_v = 6'd0;

  display_mode_ctrl #(
    .NUM_MODES   (4),
    .MODE_W      (2),
    .AUTO_FRAMES (3),
    .BLANK_FRAMES(1)
  ) dut (
    .vga_clk    (vga_clk),
    .sys_rst    (sys_rst),
    .frame_start(frame_start),
    .key_next   (key_next),
    .key_prev   (key_prev),
    .key_auto   (key_auto),
    .mode_sel   (mode_sel),
    .blank      (blank),
    .pending    (pending),
    .auto_en    (auto_en),
    .switch_done(switch_done)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  function automatic logic [5:0] out_v();
    return {mode_sel, blank, pending, auto_en, switch_done};
  endfunction

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
    n_tests++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, actual, required);
    end
  endtask

  // Expected vector layout: {mode_sel, blank, pending, auto_en, switch_done}.
  task automatic exp_at(input int c, input logic [1:0] m, input logic b, input logic p,
                        input logic a, input logic d);
    exp_t e;
    e.cyc = c;
    e.v   = {m, b, p, a, d};
    q.push_back(e);
  endtask

  // Inputs are held across exactly one rising edge; on return cyc names that edge.
  task automatic drive(input logic fs, input logic kn, input logic kp, input logic ka);
    frame_start = fs;
    key_next    = kn;
    key_prev    = kp;
    key_auto    = ka;
    @(posedge vga_clk);
    #1;
    frame_start = 1'b0;
    key_next    = 1'b0;
    key_prev    = 1'b0;
    key_auto    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  always @(negedge vga_clk) begin
    logic [5:0] cur;
    exp_t       e;
    cur = out_v();
    if (cur !== prev_v) begin
      n_evt++;
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL evt%0d: unexpected change to %b at cycle %0d", n_evt, cur, cyc);
      end else begin
        e = q.pop_front();
        if (cur !== e.v || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL evt%0d: got %b at cycle %0d, expected %b at cycle %0d",
                   n_evt, cur, cyc, e.v, e.cyc);
        end
      end
      prev_v = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b0;
    #2 sys_rst = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 sys_rst = 1'b0;
    check("reset_outputs", {2'b00, out_v()}, 8'h00);
    idle(5);

    // Basic switch with one blanked frame.
    drive(0, 1, 0, 0); exp_at(cyc, 0, 0, 1, 0, 0);
    idle(89);
    drive(1, 0, 0, 0); exp_at(cyc, 1, 1, 0, 0, 0);
    idle(99);
    drive(1, 0, 0, 0); exp_at(cyc, 1, 0, 0, 0, 1); exp_at(cyc + 1, 1, 0, 0, 0, 0);
    idle(3);

    // prev twice from mode 1 wraps to 3, then next from 3 wraps to 0.
    drive(0, 0, 1, 0); exp_at(cyc, 1, 0, 1, 0, 0);
    idle(2);
    drive(0, 0, 1, 0);
    idle(3);
    drive(1, 0, 0, 0); exp_at(cyc, 3, 1, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 0); exp_at(cyc, 3, 0, 0, 0, 1); exp_at(cyc + 1, 3, 0, 0, 0, 0);
    idle(3);
    drive(0, 1, 0, 0); exp_at(cyc, 3, 0, 1, 0, 0);
    drive(1, 0, 0, 0); exp_at(cyc, 0, 1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 0, 0, 0, 0, 1); exp_at(cyc + 1, 0, 0, 0, 0, 0);
    idle(3);

    // next then prev cancels: pending drops, no switch, no blank.
    drive(0, 1, 0, 0); exp_at(cyc, 0, 0, 1, 0, 0);
    idle(2);
    drive(0, 0, 1, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 0, 0, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 0);
    idle(3);

    // Request coinciding with frame_start waits for the following frame.
    drive(1, 1, 0, 0); exp_at(cyc, 0, 0, 1, 0, 0);
    idle(3);
    drive(1, 0, 0, 0); exp_at(cyc, 1, 1, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 0); exp_at(cyc, 1, 0, 0, 0, 1); exp_at(cyc + 1, 1, 0, 0, 0, 0);
    idle(3);
    drive(0, 1, 1, 0);
    check("both_keys_pending", {7'd0, pending}, 8'd0);
    idle(2);
    drive(1, 0, 0, 0);
    idle(3);

    // Request during BLANK re-queues after blanking ends.
    drive(0, 1, 0, 0); exp_at(cyc, 1, 0, 1, 0, 0);
    drive(1, 0, 0, 0); exp_at(cyc, 2, 1, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0); exp_at(cyc, 2, 1, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 2, 0, 1, 0, 1); exp_at(cyc + 1, 2, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 3, 1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 3, 0, 0, 0, 1); exp_at(cyc + 1, 3, 0, 0, 0, 0);
    idle(3);

    // Slideshow with AUTO_FRAMES=3: step raised on 3rd frame, applied on 4th.
    drive(0, 0, 0, 1); exp_at(cyc, 3, 0, 0, 1, 0);
    idle(2);
    drive(1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 3, 0, 1, 1, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 0, 1, 0, 1, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 0, 0, 0, 1, 1); exp_at(cyc + 1, 0, 0, 0, 1, 0);
    idle(2);
    drive(0, 0, 0, 1); exp_at(cyc, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle(2);
      drive(1, 0, 0, 0);
    end
    idle(3);

    // Asynchronous reset in the middle of a blanked frame.
    drive(0, 1, 0, 0); exp_at(cyc, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0); exp_at(cyc, 1, 1, 0, 0, 0);
    idle(5);
    #2 sys_rst = 1'b1;
    exp_at(cyc, 0, 0, 0, 0, 0);
    #1;
    check("async_reset_outputs", {2'b00, out_v()}, 8'h00);
    @(posedge vga_clk);
    #3 sys_rst = 1'b0;
    @(posedge vga_clk);
    #1;
    check("after_reset_outputs", {2'b00, out_v()}, 8'h00);
    drive(0, 1, 0, 0); exp_at(cyc, 0, 0, 1, 0, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 1, 1, 0, 0, 0);
    idle(2);
    drive(1, 0, 0, 0); exp_at(cyc, 1, 0, 0, 0, 1); exp_at(cyc + 1, 1, 0, 0, 0, 0);
    idle(5);

    check("events_outstanding", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
